// File: rtl/bp_update_queue_if.sv
// Branch-resolution enqueue and predictor-update dequeue handshakes for bp_update_queue.
interface bp_update_queue_if #(
    parameter int PC_W = 10
);
    logic            in_valid;
    logic [PC_W-1:0] in_pc;
    logic            in_taken;
    logic            in_pred;
    logic            in_ready;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic            upd_ready;

    modport slave (
        input  in_valid, in_pc, in_taken, in_pred, upd_ready,
        output in_ready, upd_valid, upd_pc, upd_taken
    );

    modport master (
        output in_valid, in_pc, in_taken, in_pred, upd_ready,
        input  in_ready, upd_valid, upd_pc, upd_taken
    );
endinterface

// File: rtl/bp_update_queue.sv
// FIFO of resolved branches feeding the predictor update port, with mispredict pulse.
// Optional saturating branch/miss counters are enabled by defining BP_UPDATE_STATS_EN.
module bp_update_queue #(
    parameter int PC_W  = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    bp_update_queue_if.slave         bus,
    input  logic                     stats_clr,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [15:0]              branch_cnt,
    output logic [15:0]              miss_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [PC_W:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            mispredict_q, mispredict_d;
    logic            push, pop, miss;

    assign bus.in_ready  = (count_q != FULL);
    assign bus.upd_valid = (count_q != '0);
    assign {bus.upd_taken, bus.upd_pc} = mem_q[rd_ptr_q];
    assign occupancy  = count_q;
    assign mispredict = mispredict_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.upd_valid && bus.upd_ready;
    assign miss = bus.in_pred != bus.in_taken;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        mispredict_d = push && miss;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            mispredict_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mispredict_q <= mispredict_d;
        end
    end

    // Storage is deliberately left unreset; upd_* payload is only meaningful with upd_valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.in_taken, bus.in_pc};
    end

`ifdef BP_UPDATE_STATS_EN
    logic [15:0] branch_q, branch_d;
    logic [15:0] miss_q, miss_d;

    always_comb begin
        branch_d = branch_q;
        miss_d   = miss_q;
        if (stats_clr) begin
            branch_d = '0;
            miss_d   = '0;
        end else if (push) begin
            if (branch_q != '1)     branch_d = branch_q + 16'd1;
            if (miss && miss_q != '1) miss_d = miss_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_q <= '0;
            miss_q   <= '0;
        end else begin
            branch_q <= branch_d;
            miss_q   <= miss_d;
        end
    end

    assign branch_cnt = branch_q;
    assign miss_cnt   = miss_q;
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign branch_cnt = '0;
    assign miss_cnt   = '0;
`endif
endmodule
